switch_control: RTL and testbench
=================================

Name: switch_control

Overview:
- Per-router arbitration and crossbar-allocation stage.
- Sits between the five input buffers and the XY routing decision.
- Round-robin picks one pending header, presents its destination to the XY routing logic, and reserves the resulting output port if it is free.
- Drives the crossbar select tables, acknowledges the header to the buffer, and releases output ports when packets finish.

Parameters:
- adress, 16'h0000, router address: x in [`TAM_FLIT-1:`METADEFLIT], y in [`METADEFLIT-1:0]; passed unchanged to the routing sub-module.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- h  in  `NPORT  header request per input port; held by the buffer until acked.
- data  in  `NPORT*`TAM_FLIT  head flit per input port; port i occupies bits [i*`TAM_FLIT +: `TAM_FLIT].
- sender  in  `NPORT  per input port, high while its packet is still being forwarded.
- ack_h  out  `NPORT  registered one-cycle header acknowledge, one-hot.
- free  out  `NPORT  output port unallocated (1 = free).
- mux_in  out  `NPORT*`PORT_IDX_W  per input port: index of the output it drives.
- mux_out  out  `NPORT*`PORT_IDX_W  per output port: index of the input feeding it.

Behaviour:
- Port indices: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- Reset (reset==0, async):
  - state=S_IDLE, prev=LOCAL (4), sel=0, target=0.
  - ack_h=0, free=5'b11111, mux_in=0, mux_out=0.
  - Effect is immediate in any state; an in-flight arbitration is discarded and no ack is issued.
- FSM, all transitions on the rising clock:
  - S_IDLE: if |h then S_ARB.
  - S_ARB: round-robin scan of h in order (prev+1)%5, (prev+2)%5 ... prev. Latch the first set index into sel and data[sel] into dest_reg. Go to S_ROUTE. If h dropped to 0, go to S_IDLE.
  - S_ROUTE: combinational routing of dest_reg gives a one-hot outputPort and find. If find==`validRegion, outputPort is one-hot, and free[target]==1:
    - free[target]<=0, mux_out[target]<=sel, mux_in[sel]<=target, ack_h[sel]<=1.
    - prev<=sel; go to S_GRANT.
  - S_ROUTE otherwise (blocked): prev<=sel, no ack, go to S_IDLE. The requester keeps h high and is retried after the others have had a turn.
  - S_GRANT: ack_h<=0; go to S_IDLE.
- Latency: h seen in S_IDLE at edge k gives ack_h high during the cycle after edge k+2 (3 edges). Minimum spacing between grants is 4 cycles.
- Release runs every cycle, independent of the FSM: for each output o with free[o]==0, if sender[mux_out[o]]==0 then free[o]<=1 at the next edge. mux_in and mux_out keep their stale values after release.
- Simultaneous release and grant:
  - S_ROUTE reads the registered free, so a port released at edge n can be granted no earlier than S_ROUTE after edge n.
  - Release of port p and grant of port q≠p in the same edge are independent.
  - The same port cannot be both released and granted in one edge.
- Only one grant is in flight at a time, so ack_h has at most one bit set.
- Widths:
  - `PORT_IDX_W=3.
  - target is the 3-bit encode of the one-hot outputPort.
  - The round-robin modulo wraps 4→0.

Decomposition:
- defines.vh holds `TAM_FLIT, `METADEFLIT, `NPORT, `EAST/`WEST/`NORTH/`SOUTH/`LOCAL, `ROUTERCONTROL, `validRegion, plus the new `PORT_IDX_W and the FSM state encodings.
- One sub-module: the existing routingMechanism, instantiated with adress=adress, dest=dest_reg, consuming outputPort and find.
- The round-robin scan is a function inside switch_control.

Test Plan (adress=16'h0101):
- Reset, then idle 10 cycles → free=5'b11111, ack_h=0, mux_in=mux_out=0, FSM stays in S_IDLE.
- h[LOCAL]=1, data[LOCAL]=16'h0201 → ack_h=5'b10000 for exactly one cycle, 3 edges later; free=5'b11110; mux_out[EAST]=4; mux_in[LOCAL]=0.
- With reset-state prev=4, h[WEST] and h[NORTH] both asserted, both heads 16'h0101 →
  - WEST granted first: mux_out[LOCAL]=1, free[LOCAL]=0.
  - NORTH is retried and blocked while sender[WEST]=1.
  - Drop sender[WEST] → free[LOCAL]=1 one edge later, then NORTH granted with mux_out[LOCAL]=2.
- All five h set with heads to distinct free outputs → ack order EAST, WEST, NORTH, SOUTH, LOCAL, one grant every 4 cycles.
- Grant LOCAL→SOUTH (head 16'h0100), hold sender[LOCAL]=1 for 20 cycles, then drop it → free[SOUTH] stays 0 until exactly one edge after sender falls.
- Assert reset low during S_ROUTE of a grantable request → outputs return to reset values immediately; no ack_h pulse; after release the request is re-arbitrated and granted normally.

Source files
------------

// File: rtl/switch_control_pkg.sv
// Shared constants, state encoding and small helpers for the switch allocator.
package switch_control_pkg;

  localparam int TAM_FLIT   = 16;  // flit width
  localparam int METADEFLIT = 8;   // half flit: y coordinate width
  localparam int NPORT      = 5;   // router ports
  localparam int PORT_IDX_W = 3;   // width of a port index

  // Port indices
  localparam logic [PORT_IDX_W-1:0] EAST  = 3'd0;
  localparam logic [PORT_IDX_W-1:0] WEST  = 3'd1;
  localparam logic [PORT_IDX_W-1:0] NORTH = 3'd2;
  localparam logic [PORT_IDX_W-1:0] SOUTH = 3'd3;
  localparam logic [PORT_IDX_W-1:0] LOCAL = 3'd4;
  localparam logic [PORT_IDX_W-1:0] LAST_PORT = 3'd4;

  // Routing result qualifier
  localparam logic [1:0] ROUTERCONTROL = 2'b00;  // no usable decision
  localparam logic [1:0] VALID_REGION  = 2'b01;  // outputPort is usable

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ROUTE = 2'd2,
    S_GRANT = 2'd3
  } sc_state_e;

  // Binary index of the set bit of a one-hot port vector.
  function automatic logic [PORT_IDX_W-1:0] onehot_encode(input logic [NPORT-1:0] oh);
    logic [PORT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (oh[i]) idx = PORT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_control_routing.sv
// XY routing: resolve the X coordinate first, then Y, else deliver locally.
module routingMechanism
  import switch_control_pkg::*;
#(
  parameter logic [TAM_FLIT-1:0] adress = 16'h0000
) (
  input  logic [TAM_FLIT-1:0] dest_i,
  output logic [NPORT-1:0]    output_port_o,
  output logic [1:0]          find_o
);

  localparam logic [TAM_FLIT-METADEFLIT-1:0] X_CUR = adress[TAM_FLIT-1:METADEFLIT];
  localparam logic [METADEFLIT-1:0]          Y_CUR = adress[METADEFLIT-1:0];

  logic [TAM_FLIT-METADEFLIT-1:0] x_dst;
  logic [METADEFLIT-1:0]          y_dst;

  assign x_dst = dest_i[TAM_FLIT-1:METADEFLIT];
  assign y_dst = dest_i[METADEFLIT-1:0];

  // Pick exactly one output direction for the latched destination.
  always_comb begin
    output_port_o = '0;
    find_o        = VALID_REGION;
    if (x_dst > X_CUR)      output_port_o[EAST]  = 1'b1;
    else if (x_dst < X_CUR) output_port_o[WEST]  = 1'b1;
    else if (y_dst > Y_CUR) output_port_o[NORTH] = 1'b1;
    else if (y_dst < Y_CUR) output_port_o[SOUTH] = 1'b1;
    else                    output_port_o[LOCAL] = 1'b1;
  end

endmodule

// File: rtl/switch_control.sv
// Round-robin header arbitration, output-port reservation and release.
module switch_control
  import switch_control_pkg::*;
#(
  parameter logic [TAM_FLIT-1:0] adress = 16'h0000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NPORT-1:0]            h,
  input  logic [NPORT*TAM_FLIT-1:0]   data,
  input  logic [NPORT-1:0]            sender,
  output logic [NPORT-1:0]            ack_h,
  output logic [NPORT-1:0]            free,
  output logic [NPORT*PORT_IDX_W-1:0] mux_in,
  output logic [NPORT*PORT_IDX_W-1:0] mux_out
);

  sc_state_e                 state_q, state_d;
  logic [PORT_IDX_W-1:0]     prev_q, prev_d;
  logic [PORT_IDX_W-1:0]     sel_q, sel_d;
  logic [TAM_FLIT-1:0]       dest_q, dest_d;
  logic [NPORT-1:0]          ack_q, ack_d;
  logic [NPORT-1:0]          free_q, free_d;
  logic [PORT_IDX_W-1:0]     mux_in_q[NPORT], mux_in_d[NPORT];
  logic [PORT_IDX_W-1:0]     mux_out_q[NPORT], mux_out_d[NPORT];

  logic [TAM_FLIT-1:0]       head[NPORT];
  logic [NPORT-1:0]          output_port;
  logic [1:0]                find;
  logic [PORT_IDX_W-1:0]     target;
  logic                      route_ok;

  // First requester after the last winner, wrapping 4 -> 0.
  function automatic logic [PORT_IDX_W-1:0] rr_pick(input logic [NPORT-1:0] req,
                                                     input logic [PORT_IDX_W-1:0] last);
    logic [PORT_IDX_W-1:0] idx;
    logic [PORT_IDX_W-1:0] pick;
    logic                  found;
    idx   = last;
    pick  = last;
    found = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      idx = (idx == LAST_PORT) ? '0 : idx + 3'd1;
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Unpack heads and pack the select tables.
  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
      assign head[gi] = data[gi*TAM_FLIT +: TAM_FLIT];
      assign mux_in[gi*PORT_IDX_W +: PORT_IDX_W]  = mux_in_q[gi];
      assign mux_out[gi*PORT_IDX_W +: PORT_IDX_W] = mux_out_q[gi];
    end
  endgenerate

  routingMechanism #(.adress(adress)) u_routing (
    .dest_i        (dest_q),
    .output_port_o (output_port),
    .find_o        (find)
  );

  assign target   = onehot_encode(output_port);
  assign route_ok = (find == VALID_REGION) && (output_port != '0)
                    && ((output_port & (output_port - 5'd1)) == '0);

  assign ack_h = ack_q;
  assign free  = free_q;

  // Next-state: arbitration FSM plus the free-running port release.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    sel_d     = sel_q;
    dest_d    = dest_q;
    ack_d     = ack_q;
    free_d    = free_q;
    mux_in_d  = mux_in_q;
    mux_out_d = mux_out_q;

    for (int o = 0; o < NPORT; o++) begin
      if (!free_q[o] && !sender[mux_out_q[o]]) free_d[o] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (|h) state_d = S_ARB;
      end
      S_ARB: begin
        if (|h) begin
          sel_d   = rr_pick(h, prev_q);
          dest_d  = head[sel_d];
          state_d = S_ROUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUTE: begin
        // Winner goes to the back of the queue whether granted or blocked.
        prev_d  = sel_q;
        state_d = S_IDLE;
        if (route_ok && free_q[target]) begin
          free_d[target]    = 1'b0;
          mux_out_d[target] = sel_q;
          mux_in_d[sel_q]   = target;
          ack_d             = '0;
          ack_d[sel_q]      = 1'b1;
          state_d           = S_GRANT;
        end
      end
      S_GRANT: begin
        ack_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      prev_q  <= LOCAL;
      sel_q   <= '0;
      dest_q  <= '0;
      ack_q   <= '0;
      free_q  <= '1;
      for (int i = 0; i < NPORT; i++) begin
        mux_in_q[i]  <= '0;
        mux_out_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      sel_q     <= sel_d;
      dest_q    <= dest_d;
      ack_q     <= ack_d;
      free_q    <= free_d;
      mux_in_q  <= mux_in_d;
      mux_out_q <= mux_out_d;
    end
  end

endmodule

// File: tb/tb_switch_control.sv
// Bench for switch_control: directed scenarios plus random traffic vs a behavioural model.
module tb_switch_control;
  import switch_control_pkg::*;

  localparam logic [15:0] ADDR = 16'h0101;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  h = '0;
  logic [4:0]  sender = '0;
  logic [79:0] data = '0;
  logic [4:0]  ack_h, free;
  logic [14:0] mux_in, mux_out;

  int checks = 0;
  int errors = 0;
  int hold[5];
  int cnt[5];

  // Behavioural model state
  int         m_phase, m_prev, m_sel, m_dest;
  logic [4:0] m_free, m_ack;
  int         m_in[5], m_out[5];

  always #5 clock = ~clock;

  switch_control #(.adress(ADDR)) dut (
    .clock   (clock),
    .reset   (reset),
    .h       (h),
    .data    (data),
    .sender  (sender),
    .ack_h   (ack_h),
    .free    (free),
    .mux_in  (mux_in),
    .mux_out (mux_out)
  );

  function automatic int mo(input int o);
    return int'(mux_out[o*3 +: 3]);
  endfunction

  function automatic int mi(input int i);
    return int'(mux_in[i*3 +: 3]);
  endfunction

  // XY routing: east/west until the column matches, then north/south, else local.
  function automatic int xy(input int d);
    int a, cx, cy, dx, dy;
    a  = int'(ADDR);
    cx = a / 256;
    cy = a % 256;
    dx = d / 256;
    dy = d % 256;
    if (dx > cx) return 0;
    if (dx < cx) return 1;
    if (dy > cy) return 2;
    if (dy < cy) return 3;
    return 4;
  endfunction

  // Model: a grant decision is a three-edge sequence (notice, pick, decide),
  // followed by one edge of ack; outputs are released when their feeder stops.
  always @(posedge clock or negedge reset) begin
    logic [4:0] rel;
    int p;
    bit found;
    if (!reset) begin
      m_phase = 0; m_prev = 4; m_sel = 0; m_dest = 0;
      m_free = 5'h1f; m_ack = '0;
      for (int i = 0; i < 5; i++) begin m_in[i] = 0; m_out[i] = 0; end
    end else begin
      rel = '0;
      for (int o = 0; o < 5; o++)
        if (!m_free[o] && !sender[m_out[o]]) rel[o] = 1'b1;
      case (m_phase)
        0: if (h != 0) m_phase = 1;
        1: begin
          if (h == 0) m_phase = 0;
          else begin
            found = 0;
            for (int k = 1; k <= 5; k++) begin
              p = (m_prev + k) % 5;
              if (!found && h[p]) begin m_sel = p; found = 1; end
            end
            m_dest  = int'(data[m_sel*16 +: 16]);
            m_phase = 2;
          end
        end
        2: begin
          p = xy(m_dest);
          m_prev = m_sel;
          if (m_free[p]) begin
            m_free[p]   = 1'b0;
            m_out[p]    = m_sel;
            m_in[m_sel] = p;
            m_ack       = 5'(1 << m_sel);
            m_phase     = 3;
          end else m_phase = 0;
        end
        default: begin m_ack = '0; m_phase = 0; end
      endcase
      m_free = m_free | rel;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: compare against the model, then act as the input buffers.
  task automatic tick();
    @(posedge clock);
    #1;
    if (reset) begin
      check("model_ack", ack_h, m_ack);
      check("model_free", free, m_free);
      for (int i = 0; i < 5; i++) begin
        check("model_mux_in", mi(i), m_in[i]);
        check("model_mux_out", mo(i), m_out[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (sender[i] && cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) sender[i] = 1'b0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (ack_h[i]) begin
        h[i] = 1'b0;
        sender[i] = 1'b1;
        cnt[i] = hold[i];
      end
    end
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack_h == 0 && n < limit);
    check("ack_within_bound", int'(ack_h != 0), 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    h = '0;
    sender = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drop_sender(input int i);
    sender[i] = 1'b0;
    cnt[i] = 0;
  endtask

  initial begin
    int n, seen;
    logic [15:0] heads[5];
    for (int i = 0; i < 5; i++) begin hold[i] = -1; cnt[i] = 0; end

    // Reset and idle
    do_reset();
    repeat (10) tick();
    check("idle_free", free, 5'h1f);
    check("idle_ack", ack_h, 0);
    check("idle_mux_in", mux_in, 0);
    check("idle_mux_out", mux_out, 0);
    $display("txn idle: free=%b ack=%b", free, ack_h);

    // LOCAL -> EAST, 3-edge latency, one-cycle ack
    data[4*16 +: 16] = 16'h0201;
    h[4] = 1'b1;
    tick(); check("lat_edge1", ack_h, 0);
    tick(); check("lat_edge2", ack_h, 0);
    tick(); check("lat_edge3", ack_h, 5'b10000);
    tick(); check("ack_one_cycle", ack_h, 0);
    check("local_free", free, 5'b11110);
    check("local_mux_out_east", mo(0), 4);
    check("local_mux_in_local", mi(4), 0);
    $display("txn local->east: free=%b mux_out=%h mux_in=%h", free, mux_out, mux_in);
    drop_sender(4);
    tick(); check("local_release", free, 5'h1f);

    // WEST and NORTH contend for LOCAL
    do_reset();
    data[1*16 +: 16] = 16'h0101;
    data[2*16 +: 16] = 16'h0101;
    h[1] = 1'b1; h[2] = 1'b1;
    wait_ack(20, n);
    check("west_first", ack_h, 5'b00010);
    check("west_mux_out", mo(4), 1);
    check("west_free_local", int'(free[4]), 0);
    $display("txn west->local: ack=%b free=%b", ack_h, free);
    seen = 0;
    repeat (20) begin tick(); if (ack_h != 0) seen++; end
    check("north_blocked", seen, 0);
    drop_sender(1);
    tick(); check("local_released", int'(free[4]), 1);
    wait_ack(20, n);
    check("north_second", ack_h, 5'b00100);
    check("north_mux_out", mo(4), 2);
    $display("txn north->local: ack=%b mux_out=%h", ack_h, mux_out);
    drop_sender(2);
    repeat (2) tick();

    // All five to distinct outputs
    do_reset();
    heads[0] = 16'h0201; heads[1] = 16'h0001; heads[2] = 16'h0102;
    heads[3] = 16'h0100; heads[4] = 16'h0101;
    for (int i = 0; i < 5; i++) begin data[i*16 +: 16] = heads[i]; h[i] = 1'b1; end
    for (int k = 0; k < 5; k++) begin
      wait_ack(30, n);
      check("rr_order", ack_h, 1 << k);
      check("rr_spacing", n, (k == 0) ? 3 : 4);
      $display("txn rr grant %0d: ack=%b after %0d cycles", k, ack_h, n);
    end
    tick();
    check("all_busy", free, 0);
    for (int i = 0; i < 5; i++) drop_sender(i);
    repeat (2) tick();

    // LOCAL -> SOUTH with a long packet
    data[4*16 +: 16] = 16'h0100;
    h[4] = 1'b1;
    wait_ack(20, n);
    check("south_ack", ack_h, 5'b10000);
    check("south_mux_out", mo(3), 4);
    seen = 0;
    repeat (20) begin tick(); if (free[3]) seen++; end
    check("south_held", seen, 0);
    drop_sender(4);
    check("south_before_edge", int'(free[3]), 0);
    tick();
    check("south_after_edge", int'(free[3]), 1);
    $display("txn local->south release: free=%b", free);

    // Reset during the route decision
    data[0] = 1'b0;
    data[0*16 +: 16] = 16'h0201;
    h[0] = 1'b1;
    tick(); tick();
    #3 reset = 1'b0;
    #1;
    check("rst_ack", ack_h, 0);
    check("rst_free", free, 5'h1f);
    check("rst_mux_in", mux_in, 0);
    check("rst_mux_out", mux_out, 0);
    seen = 0;
    repeat (2) begin tick(); if (ack_h != 0) seen++; end
    check("rst_no_ack", seen, 0);
    @(negedge clock) reset = 1'b1;
    wait_ack(10, n);
    check("rst_regrant", ack_h, 5'b00001);
    check("rst_regrant_lat", n, 3);
    check("rst_regrant_free", free, 5'b11110);
    $display("txn reset-in-route regrant: ack=%b free=%b", ack_h, free);
    drop_sender(0);
    repeat (2) tick();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (!h[i] && !sender[i] && $urandom_range(0, 3) == 0) begin
          data[i*16 +: 16] = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))};
          hold[i] = $urandom_range(1, 10);
          h[i] = 1'b1;
        end
      end
      tick();
      if (ack_h != 0)
        $display("txn random cycle %0d: ack=%b free=%b", c, ack_h, free);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
